// File: rtl/seq_alu_n.sv
// seq_alu_n: registered multi-cycle N-bit ALU with valid/ready handshakes.
// Single-cycle ops finish one edge after accept. Shifts by s>0 take s
// iterations, one bit per cycle. Popcount (HAMM) takes N iterations.
// RES/zero/ovf are written only when the FSM enters DONE.
module seq_alu_n #(
  parameter int N  = 32,
  parameter int SW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [3:0]   func,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] RES,
  output logic         zero,
  output logic         ovf
);

  // Operation encoding shared with the rest of the pipeline
  localparam logic [3:0] F_ADD  = 4'd0;
  localparam logic [3:0] F_SUB  = 4'd1;
  localparam logic [3:0] F_AND  = 4'd2;
  localparam logic [3:0] F_OR   = 4'd3;
  localparam logic [3:0] F_XOR  = 4'd4;
  localparam logic [3:0] F_NOR  = 4'd5;
  localparam logic [3:0] F_SLL  = 4'd6;
  localparam logic [3:0] F_SRL  = 4'd7;
  localparam logic [3:0] F_SRA  = 4'd8;
  localparam logic [3:0] F_SLT  = 4'd9;
  localparam logic [3:0] F_SGT  = 4'd10;
  localparam logic [3:0] F_NOT  = 4'd11;
  localparam logic [3:0] F_INC  = 4'd12;
  localparam logic [3:0] F_DEC  = 4'd13;
  localparam logic [3:0] F_HAMM = 4'd14;
  localparam logic [3:0] F_LUI  = 4'd15;

  // The iteration counter must be able to hold N itself (HAMM length)
  localparam logic [SW:0]  HAMM_CNT = (SW+1)'(N);
  localparam logic [SW:0]  CNT_ONE  = (SW+1)'(1);
  localparam logic [N-1:0] ONE_N    = N'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q;
  logic [3:0]  op_q;
  logic [N-1:0] work_q;
  logic [SW:0] cnt_q;
  logic [SW:0] acc_q;
  logic [N-1:0] res_q;
  logic        zero_q;
  logic        ovf_q;
  logic        out_valid_q;

  // Handshake and op classification
  logic          accept;
  logic [SW-1:0] shamt;
  logic          is_shift;
  logic          is_hamm;
  logic          is_multi;

  assign in_ready = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
  assign accept   = in_valid & in_ready;
  assign shamt    = B[SW-1:0];
  assign is_shift = (func == F_SLL) | (func == F_SRL) | (func == F_SRA);
  assign is_hamm  = (func == F_HAMM);
  // A zero-distance shift is just a copy of A, so it takes the fast path
  assign is_multi = is_hamm | (is_shift & (shamt != '0));

  // Bitwise logic lanes
  logic [N-1:0] and_v;
  logic [N-1:0] or_v;
  logic [N-1:0] xor_v;
  logic [N-1:0] nor_v;

  for (genvar gi = 0; gi < N; gi++) begin : g_bitwise
    assign and_v[gi] = A[gi] & B[gi];
    assign or_v[gi]  = A[gi] | B[gi];
    assign xor_v[gi] = A[gi] ^ B[gi];
    assign nor_v[gi] = ~(A[gi] | B[gi]);
  end

  logic [N-1:0] add_v;
  logic [N-1:0] sub_v;
  logic         lt_s;
  logic         gt_s;

  assign add_v = A + B;
  assign sub_v = A - B;
  assign lt_s  = $signed(A) < $signed(B);
  assign gt_s  = $signed(A) > $signed(B);

  logic [N-1:0] one_res;
  logic         one_ovf;

  // Result of every op that completes in a single cycle, from live inputs
  always_comb begin
    one_res = '0;
    one_ovf = 1'b0;
    case (func)
      F_ADD: begin
        one_res = add_v;
        one_ovf = (A[N-1] == B[N-1]) & (add_v[N-1] != A[N-1]);
      end
      F_SUB: begin
        one_res = sub_v;
        one_ovf = (A[N-1] != B[N-1]) & (sub_v[N-1] != A[N-1]);
      end
      F_AND:  one_res = and_v;
      F_OR:   one_res = or_v;
      F_XOR:  one_res = xor_v;
      F_NOR:  one_res = nor_v;
      F_SLL,
      F_SRL,
      F_SRA:  one_res = A;
      F_SLT:  one_res = {{(N-1){1'b0}}, lt_s};
      F_SGT:  one_res = {{(N-1){1'b0}}, gt_s};
      F_NOT:  one_res = ~A;
      F_INC:  one_res = A + ONE_N;
      F_DEC:  one_res = A - ONE_N;
      F_HAMM: one_res = '0;
      F_LUI:  one_res = A << (N/2);
      default: one_res = '0;
    endcase
  end

  // Per-iteration datapath for the multi-cycle ops
  logic [N-1:0] step_d;
  logic [SW:0]  acc_d;
  logic [N-1:0] calc_res;
  logic         last_iter;

  // One-bit step of the working register; HAMM consumes bits from the LSB
  always_comb begin
    step_d = work_q >> 1;
    case (op_q)
      F_SLL:   step_d = work_q << 1;
      F_SRL:   step_d = work_q >> 1;
      F_SRA:   step_d = {work_q[N-1], work_q[N-1:1]};
      default: step_d = work_q >> 1;
    endcase
  end

  assign acc_d     = acc_q + {{SW{1'b0}}, work_q[0]};
  assign last_iter = (cnt_q == CNT_ONE);
  assign calc_res  = (op_q == F_HAMM) ? {{(N-SW-1){1'b0}}, acc_d} : step_d;

  // Control FSM with all datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      work_q      <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      res_q       <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE,
        S_DONE: begin
          if (accept) begin
            op_q <= func;
            if (is_multi) begin
              // Result registers keep their old value until DONE
              state_q     <= S_CALC;
              out_valid_q <= 1'b0;
              work_q      <= A;
              acc_q       <= '0;
              cnt_q       <= is_hamm ? HAMM_CNT : {1'b0, shamt};
            end else begin
              state_q     <= S_DONE;
              out_valid_q <= 1'b1;
              res_q       <= one_res;
              zero_q      <= (one_res == '0);
              ovf_q       <= one_ovf;
            end
          end else if ((state_q == S_DONE) && out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        S_CALC: begin
          work_q <= step_d;
          acc_q  <= acc_d;
          cnt_q  <= cnt_q - CNT_ONE;
          if (last_iter) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            res_q       <= calc_res;
            zero_q      <= (calc_res == '0);
            ovf_q       <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign RES       = res_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_alu_n.sv
// Directed bench for seq_alu_n (N=32): hand-computed results, latency,
// stall length, backpressure and mid-operation reset.
module tb_seq_alu_n;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  func;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] RES;
  logic        zero;
  logic        ovf;

  int checks   = 0;
  int failures = 0;

  seq_alu_n #(.N(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .func      (func),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .RES       (RES),
    .zero      (zero),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op from IDLE, wait for its result, check it, let it drain.
  task automatic do_op(input string tag, input logic [3:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res,
                       input logic exp_z, input logic exp_o,
                       input int exp_lat, input int exp_low);
    int lat;
    int low;
    check_eq({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    func     = f;
    A        = a;
    B        = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    // Scramble operands: the DUT must have latched them at accept
    A    = ~a;
    B    = b ^ 32'h5A5A_A5A5;
    func = ~f;
    lat  = 1;
    low  = 0;
    while (!out_valid && lat < 200) begin
      if (!in_ready) low++;
      step();
      lat++;
    end
    check_eq({tag, "_lat"}, lat, exp_lat);
    check_eq({tag, "_stall"}, low, exp_low);
    check_eq({tag, "_res"}, RES, exp_res);
    check_eq({tag, "_zero"}, {31'd0, zero}, {31'd0, exp_z});
    check_eq({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_o});
    $display("TXN %-6s func=%0d A=0x%08h B=0x%08h -> RES=0x%08h zero=%0b ovf=%0b lat=%0d",
             tag, f, a, b, RES, zero, ovf, lat);
    step();
    check_eq({tag, "_drain"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    A         = '0;
    B         = '0;
    func      = '0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_res", RES, 32'd0);
    check_eq("rst_zero", {31'd0, zero}, 32'd0);
    check_eq("rst_ovf", {31'd0, ovf}, 32'd0);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);

    //     tag      func   A              B              RES            z     o   lat low
    do_op("ADD",   4'd0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1, 0);
    do_op("SUB",   4'd1,  32'd5,         32'd5,         32'h0000_0000, 1'b1, 1'b0, 1, 0);
    do_op("SUBOV", 4'd1,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1, 0);
    do_op("AND",   4'd2,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 1'b0, 1'b0, 1, 0);
    do_op("OR",    4'd3,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF, 1'b0, 1'b0, 1, 0);
    do_op("XOR",   4'd4,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0, 1'b0, 1'b0, 1, 0);
    do_op("NOR",   4'd5,  32'h0000_FFFF, 32'h00FF_0000, 32'hFF00_0000, 1'b0, 1'b0, 1, 0);
    do_op("SLT",   4'd9,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1, 0);
    do_op("SGT",   4'd10, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1, 0);
    do_op("SGT2",  4'd10, 32'd5,         32'd3,         32'h0000_0001, 1'b0, 1'b0, 1, 0);
    do_op("NOT",   4'd11, 32'h0F0F_0F0F, 32'h0000_0000, 32'hF0F0_F0F0, 1'b0, 1'b0, 1, 0);
    do_op("INC",   4'd12, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1, 0);
    do_op("DEC",   4'd13, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1, 0);
    do_op("LUI",   4'd15, 32'h1234_5678, 32'h0000_0000, 32'h5678_0000, 1'b0, 1'b0, 1, 0);
    do_op("SLL0",  4'd6,  32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 1'b0, 1'b0, 1, 0);
    do_op("SLL3",  4'd6,  32'h0000_0001, 32'h0000_0003, 32'h0000_0008, 1'b0, 1'b0, 4, 3);
    do_op("SRL4",  4'd7,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0, 1'b0, 5, 4);
    do_op("SRA31", 4'd8,  32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 1'b0, 1'b0, 32, 31);
    do_op("HAMM",  4'd14, 32'hF0F0_F0F1, 32'h0000_0000, 32'd17,        1'b0, 1'b0, 33, 32);
    do_op("HAMM0", 4'd14, 32'h0000_0000, 32'h0000_0000, 32'd0,         1'b1, 1'b0, 33, 32);
    do_op("HAMM1", 4'd14, 32'hFFFF_FFFF, 32'h0000_0000, 32'd32,        1'b0, 1'b0, 33, 32);

    // Backpressure: result held while out_ready=0, new op waits
    out_ready = 1'b0;
    func      = 4'd4;
    A         = 32'hAAAA_5555;
    B         = 32'hFFFF_0000;
    in_valid  = 1'b1;
    step();
    func = 4'd0;
    A    = 32'd2;
    B    = 32'd3;
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check_eq("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check_eq("bp_res", RES, 32'h5555_5555);
      step();
    end
    $display("TXN BP     held RES=0x%08h for 5 cycles", RES);
    out_ready = 1'b1;
    #1;
    check_eq("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    check_eq("b2b_out_valid", {31'd0, out_valid}, 32'd1);
    check_eq("b2b_res", RES, 32'd5);
    check_eq("b2b_zero", {31'd0, zero}, 32'd0);
    $display("TXN B2B    ADD 2+3 -> RES=0x%08h out_valid=%0b", RES, out_valid);
    step();
    check_eq("b2b_drain", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of a popcount
    func     = 4'd14;
    A        = 32'hFFFF_FFFF;
    B        = 32'd0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (9) step();
    check_eq("mid_in_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #2;
    check_eq("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("mid_rst_res", RES, 32'd0);
    check_eq("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    $display("TXN RST    reset during HAMM -> RES=0x%08h in_ready=%0b", RES, in_ready);
    step();
    rst_n = 1'b1;
    step();
    check_eq("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    do_op("HAMMR", 4'd14, 32'hFFFF_FFFF, 32'h0000_0000, 32'd32,        1'b0, 1'b0, 33, 32);
    do_op("ADDR",  4'd0,  32'd2,         32'd3,         32'd5,         1'b0, 1'b0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
